score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Answer-checking/scoring stage between the pattern memory (exist flag) and the 7-seg display driver.
//  Debounces the player "submit" pushbutton and, on each accepted press, samples exist.
//  Counts correct/incorrect answers and computes percent-correct with a sequential divider.
//  Outputs binary scores that the display controller converts to hex digits.
// PARAMETERS
//  CNT_W           7      width of every score output
//  CNT_MAX         99     saturation value of correct_cnt and wrong_cnt
//  DEBOUNCE_CYCLES 50000  cycles of stable synced input required to accept a level change
// PORTS
//  clk          in   1      system clock
//  resetn       in   1      asynchronous, active-high reset (1 = reset)
//  game_start   in   1      one-cycle pulse from game start logic; clears all scores
//  submit_n     in   1      raw player-input pushbutton, active-low, asynchronous
//  exist        in   1      from pattern memory: 1 = current switch pattern matches stored sequence
//  correct_cnt  out  CNT_W  correct answers, 0..CNT_MAX
//  wrong_cnt    out  CNT_W  incorrect answers, 0..CNT_MAX
//  percent      out  CNT_W  100*correct/(correct+wrong), 0..100
//  busy         out  1      high from UPDATE through DONE; presses are dropped while high
//  score_valid  out  1      one-cycle pulse when all three scores are updated
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, sync flops = 1, debounced level = 1, debounce counter = 0.
//  Input path: 2-flop synchronizer on submit_n. The debounced level takes the synced value only after
//   DEBOUNCE_CYCLES consecutive cycles that differ from it. A shorter glitch restarts the counter
//   and changes nothing. A debounced 1->0 transition gives press = 1 for one cycle.
//  FSM IDLE -> UPDATE -> DIV -> DONE -> IDLE:
//   IDLE:   on press, latch exist, go to UPDATE (cycle T).
//   UPDATE: increment correct_cnt (exist=1) or wrong_cnt (exist=0); saturate at CNT_MAX, no wrap.
//           Load the divider: num = correct*100 (new counts), den = correct+wrong. Cycle T+1.
//   DIV:    14-bit restoring divide, 1 quotient bit per cycle, 14 cycles (T+2..T+15).
//           num max 9999 < 2^14. If den = 0, quotient = 0.
//   DONE:   register percent = quotient; score_valid = 1 for this one cycle (T+16); go to IDLE.
//  A saturated counter still triggers a full recompute of percent.
//  Quotient is truncated (floor) unless PERCENT_ROUND_EN is defined.
//  game_start has priority over everything:
//   - next edge: counts and percent go to 0, FSM goes to IDLE, busy = 0, score_valid = 0;
//   - a press in that same cycle is discarded;
//   - a divide in flight is aborted and never publishes.
//  Presses while busy = 1 are dropped, not queued. exist is sampled only in the press cycle.
//  Async reset mid-divide: immediate return to reset state; no partial result appears.
// CONFIGURATION
//  PERCENT_ROUND_EN defined: UPDATE loads num = correct*100 + (den>>1), giving round-half-up.
//  PERCENT_ROUND_EN undefined: num = correct*100, giving floor. Latency is identical in both builds.
// TESTING (bench uses DEBOUNCE_CYCLES = 4)
//  1 Reset: assert resetn=1 mid-operation -> all outputs 0 immediately; 20 idle cycles -> still 0.
//  2 Presses with exist = 1,1,1,0 -> correct=3, wrong=1, percent=75.
//    score_valid pulses exactly 4 times, each 16 cycles after its press pulse.
//  3 Presses with exist = 1,1,0 -> correct=2, wrong=1, percent=66 (67 with PERCENT_ROUND_EN).
//  4 submit_n low for 3 cycles then high (bounce) -> no count change, no score_valid.
//    Hold low 10 cycles -> exactly one count.
//  5 Second press during DIV -> ignored, only one count.
//    game_start during DIV -> next cycle counts=0, percent=0, busy=0, no score_valid.
//  6 105 presses with exist=1 -> correct=99 (saturated), wrong=0, percent=100.
//    One exist=0 press -> wrong=1, percent=99.

Source files
------------

// File: rtl/score_tracker.sv
// score_tracker
//   Answer-checking and scoring stage that sits between the pattern memory
//   and the 7-segment display driver.
//   - Debounces the active-low "submit" pushbutton and produces one press
//     pulse per debounced press.
//   - On each accepted press, latches `exist` and counts the answer as
//     correct or wrong. Both counters saturate at CNT_MAX.
//   - Recomputes percent-correct with a 14-cycle restoring divider.
//
// Optional build macro:
//   PERCENT_ROUND_EN  defined   -> percent is rounded half-up.
//                     undefined -> percent is truncated (floor).
//   Latency is the same in both builds.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous reset, active HIGH despite its name
//   game_start   one-cycle pulse; clears all scores and aborts any update
//   submit_n     raw pushbutton, active-low, asynchronous to clk
//   exist        1 = current switch pattern matches the stored sequence
//   correct_cnt  number of correct answers, 0..CNT_MAX
//   wrong_cnt    number of wrong answers, 0..CNT_MAX
//   percent      100*correct/(correct+wrong), 0..100
//   busy         high while an update is in progress; presses are dropped
//   score_valid  one-cycle pulse when all three scores have been refreshed
module score_tracker #(
  parameter int CNT_W           = 7,
  parameter int CNT_MAX         = 99,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             game_start,
  input  logic             submit_n,
  input  logic             exist,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] wrong_cnt,
  output logic [CNT_W-1:0] percent,
  output logic             busy,
  output logic             score_valid
);

  // Divider width: the largest numerator is 99*100 + 99 = 9999 < 2^14.
  localparam int DIV_W  = 14;
  // Denominator width: the largest denominator is 99 + 99 = 198.
  localparam int DEN_W  = 8;
  localparam int REM_W  = DEN_W + 1;
  localparam int STEP_W = 4;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DIV    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Input synchronizer and debouncer state.
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;

  // Scoring FSM and divider state.
  state_t           state_q, state_d;
  logic             exist_q, exist_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic [CNT_W-1:0] wrong_q, wrong_d;
  logic [CNT_W-1:0] percent_q, percent_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [STEP_W-1:0] step_q, step_d;

  // Combinational helper signals.
  logic [CNT_W-1:0] correct_inc, wrong_inc;
  logic [CNT_W-1:0] new_correct, new_wrong;
  logic [DEN_W-1:0] den_new;
  logic [DIV_W-1:0] num_new;
  logic [REM_W-1:0] rem_shift;
  logic             rem_ge;
  logic [DEN_W-1:0] rem_next;
  logic [DIV_W-1:0] quo_next;

  // Debouncer.
  // The debounced level follows the synchronized input only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreeing cycle
  // restarts the count, so a short glitch has no effect.
  // The press pulse is raised in the same cycle the level commits from 1 to 0.
  always_comb begin
    sync1_d  = submit_n;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
        press = deb_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Saturating increments and divider operands.
  // The operands are formed from the post-increment counts so that percent
  // always reflects the answer that was just scored.
  always_comb begin
    correct_inc = (correct_q == CNT_W'(CNT_MAX)) ? correct_q : correct_q + CNT_W'(1);
    wrong_inc   = (wrong_q == CNT_W'(CNT_MAX)) ? wrong_q : wrong_q + CNT_W'(1);
    new_correct = exist_q ? correct_inc : correct_q;
    new_wrong   = exist_q ? wrong_q : wrong_inc;
    den_new     = DEN_W'(new_correct) + DEN_W'(new_wrong);
`ifdef PERCENT_ROUND_EN
    num_new     = DIV_W'(new_correct) * DIV_W'(100) + DIV_W'(den_new >> 1);
`else
    num_new     = DIV_W'(new_correct) * DIV_W'(100);
`endif
  end

  // One restoring-division step.
  // The numerator is shifted out of the top of quo_q while quotient bits
  // are shifted in at the bottom, so after DIV_W steps quo_q holds the
  // quotient. The remainder always stays below den, so it fits in DEN_W bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[DIV_W-1]};
    rem_ge    = (rem_shift >= {1'b0, den_q});
    rem_next  = rem_ge ? DEN_W'(rem_shift - {1'b0, den_q}) : rem_shift[DEN_W-1:0];
    quo_next  = {quo_q[DIV_W-2:0], rem_ge};
  end

  // Scoring FSM: next state and outputs.
  // percent is loaded on the edge that enters DONE, so the refreshed value
  // is visible during the same cycle as the score_valid pulse.
  // game_start overrides every state, which also aborts a divide in flight.
  always_comb begin
    state_d     = state_q;
    exist_d     = exist_q;
    correct_d   = correct_q;
    wrong_d     = wrong_q;
    percent_d   = percent_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    den_d       = den_q;
    step_d      = step_q;
    score_valid = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (press) begin
          exist_d = exist;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        correct_d = new_correct;
        wrong_d   = new_wrong;
        quo_d     = num_new;
        rem_d     = '0;
        den_d     = den_new;
        step_d    = '0;
        state_d   = DIV;
      end
      DIV: begin
        quo_d  = quo_next;
        rem_d  = rem_next;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(DIV_W - 1)) begin
          percent_d = (den_q == '0) ? '0 : CNT_W'(quo_next);
          state_d   = DONE;
        end
      end
      DONE: begin
        score_valid = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (game_start) begin
      state_d   = IDLE;
      correct_d = '0;
      wrong_d   = '0;
      percent_d = '0;
    end
  end

  // State registers.
  // The synchronizer and the debounced level reset to 1 (button released),
  // so leaving reset never creates a spurious press.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      exist_q   <= 1'b0;
      correct_q <= '0;
      wrong_q   <= '0;
      percent_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      step_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      exist_q   <= exist_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      percent_q <= percent_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      den_q     <= den_d;
      step_q    <= step_d;
    end
  end

  assign correct_cnt = correct_q;
  assign wrong_cnt   = wrong_q;
  assign percent     = percent_q;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker
//   Self-checking bench for score_tracker, built with DEBOUNCE_CYCLES = 4.
//   A score model tracks correct/wrong counts using plain saturating
//   arithmetic and derives percent directly from its definition.
//   Every task starts and ends just after a falling clock edge.
module tb_score_tracker;

  localparam int DEB     = 4;
  localparam int MAX_CNT = 99;
  // Cycles from driving submit_n low to score_valid:
  // 2 synchronizer edges, DEB stable cycles until the press, then 16 cycles.
  localparam int LAT     = DEB + 17;

  logic       clk;
  logic       rst;
  logic       game_start;
  logic       submit_n;
  logic       exist;
  logic [6:0] correct_cnt;
  logic [6:0] wrong_cnt;
  logic [6:0] percent;
  logic       busy;
  logic       score_valid;

  int errors;
  int checks;
  int m_correct;
  int m_wrong;

  score_tracker #(
    .CNT_W(7),
    .CNT_MAX(99),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .resetn(rst),
    .game_start(game_start),
    .submit_n(submit_n),
    .exist(exist),
    .correct_cnt(correct_cnt),
    .wrong_cnt(wrong_cnt),
    .percent(percent),
    .busy(busy),
    .score_valid(score_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected percent derived from the current model counts.
  function automatic int m_percent();
    int den;
    den = m_correct + m_wrong;
    if (den == 0) return 0;
`ifdef PERCENT_ROUND_EN
    return (m_correct * 100 + den / 2) / den;
`else
    return (m_correct * 100) / den;
`endif
  endfunction

  // One full press: hold the button for `hold` cycles, then release it and let it settle.
  // Checks the score_valid pulse count, its latency and the scores it publishes.
  task automatic do_press(input logic ex, input int hold, input string tag);
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    exist    = ex;
    submit_n = 1'b0;
    if (ex) m_correct = (m_correct < MAX_CNT) ? m_correct + 1 : MAX_CNT;
    else    m_wrong   = (m_wrong < MAX_CNT) ? m_wrong + 1 : MAX_CNT;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k > DEB + 1) exist = 1'($urandom_range(0, 1));
      if (k == hold) submit_n = 1'b1;
      if (score_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        checks++;
        if (correct_cnt !== 7'(m_correct)) begin
          errors++;
          $display("[TB] FAIL %s correct_cnt: got %0d expected %0d", tag, correct_cnt, m_correct);
        end
        checks++;
        if (wrong_cnt !== 7'(m_wrong)) begin
          errors++;
          $display("[TB] FAIL %s wrong_cnt: got %0d expected %0d", tag, wrong_cnt, m_wrong);
        end
        checks++;
        if (percent !== 7'(m_percent())) begin
          errors++;
          $display("[TB] FAIL %s percent: got %0d expected %0d", tag, percent, m_percent());
        end
      end
    end
    submit_n = 1'b1;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL %s valid_pulses: got %0d expected 1", tag, pulses);
    end
    checks++;
    if (first != LAT) begin
      errors++;
      $display("[TB] FAIL %s valid_latency: got %0d expected %0d", tag, first, LAT);
    end
  endtask

  // Clear all scores with a one-cycle game_start pulse.
  task automatic clear_scores();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    m_correct = 0;
    m_wrong   = 0;
    checks++;
    if ({correct_cnt, wrong_cnt, percent, busy} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL clear: got c=%0d w=%0d p=%0d busy=%0b expected all 0",
               correct_cnt, wrong_cnt, percent, busy);
    end
  endtask

  // Checks that the outputs stay at the reset state for n cycles.
  task automatic check_idle_zero(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if ({correct_cnt, wrong_cnt, percent, busy, score_valid} !== 23'd0) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got c=%0d w=%0d p=%0d busy=%0b sv=%0b expected all 0",
                 tag, k, correct_cnt, wrong_cnt, percent, busy, score_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    game_start = 1'b0;
    submit_n   = 1'b1;
    exist      = 1'b0;
    #2;
    checks++;
    if ({correct_cnt, wrong_cnt, percent, busy, score_valid} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got c=%0d w=%0d p=%0d busy=%0b sv=%0b expected all 0",
               correct_cnt, wrong_cnt, percent, busy, score_valid);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_correct = 0;
    m_wrong   = 0;
    check_idle_zero(5, "post_reset");
  endtask

  task automatic test_scoring();
    do_press(1'b1, 30, "score_p1");
    do_press(1'b1, 30, "score_p2");
    do_press(1'b1, 30, "score_p3");
    do_press(1'b0, 30, "score_p4");
    checks++;
    if ({correct_cnt, wrong_cnt, percent} !== {7'd3, 7'd1, 7'd75}) begin
      errors++;
      $display("[TB] FAIL score_final: got c=%0d w=%0d p=%0d expected 3 1 75",
               correct_cnt, wrong_cnt, percent);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    seen     = 0;
    exist    = 1'b1;
    submit_n = 1'b0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("[TB] FAIL rst_div_busy: got busy=0 expected 1 within 40 cycles");
    end
    repeat (4) @(negedge clk);
    #2;
    rst      = 1'b1;
    submit_n = 1'b1;
    #1;
    checks++;
    if ({correct_cnt, wrong_cnt, percent, busy, score_valid} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL rst_div_async: got c=%0d w=%0d p=%0d busy=%0b sv=%0b expected all 0",
               correct_cnt, wrong_cnt, percent, busy, score_valid);
    end
    m_correct = 0;
    m_wrong   = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_zero(20, "rst_div_idle");
  endtask

  task automatic test_round_case();
    do_press(1'b1, 30, "three_p1");
    do_press(1'b1, 30, "three_p2");
    do_press(1'b0, 30, "three_p3");
    checks++;
`ifdef PERCENT_ROUND_EN
    if (percent !== 7'd67) begin
      errors++;
      $display("[TB] FAIL three_percent: got %0d expected 67", percent);
    end
`else
    if (percent !== 7'd66) begin
      errors++;
      $display("[TB] FAIL three_percent: got %0d expected 66", percent);
    end
`endif
  endtask

  task automatic test_bounce();
    int sv_seen;
    int c0;
    int w0;
    sv_seen = 0;
    c0 = m_correct;
    w0 = m_wrong;
    exist    = 1'b1;
    submit_n = 1'b0;
    repeat (3) @(negedge clk);
    submit_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (score_valid === 1'b1 || busy === 1'b1) sv_seen++;
    end
    checks++;
    if (sv_seen != 0) begin
      errors++;
      $display("[TB] FAIL bounce_activity: got %0d active cycles expected 0", sv_seen);
    end
    checks++;
    if (correct_cnt !== 7'(c0) || wrong_cnt !== 7'(w0)) begin
      errors++;
      $display("[TB] FAIL bounce_counts: got c=%0d w=%0d expected c=%0d w=%0d",
               correct_cnt, wrong_cnt, c0, w0);
    end
    do_press(1'b1, 10, "bounce_hold10");
  endtask

  task automatic test_back_to_back();
    int seen;
    int pulses;
    seen   = 0;
    pulses = 0;
    exist    = 1'b1;
    submit_n = 1'b0;
    m_correct = (m_correct < MAX_CNT) ? m_correct + 1 : MAX_CNT;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("[TB] FAIL b2b_busy: got busy=0 expected 1 within 40 cycles");
    end
    submit_n = 1'b1;
    repeat (7) @(negedge clk);
    // A second press that matures while the divide is still running.
    exist    = 1'b0;
    submit_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) submit_n = 1'b1;
      if (score_valid === 1'b1) begin
        pulses++;
        checks++;
        if ({correct_cnt, wrong_cnt, percent} !== {7'(m_correct), 7'(m_wrong), 7'(m_percent())}) begin
          errors++;
          $display("[TB] FAIL b2b_scores: got c=%0d w=%0d p=%0d expected %0d %0d %0d",
                   correct_cnt, wrong_cnt, percent, m_correct, m_wrong, m_percent());
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_game_start();
    int seen;
    int active;
    seen   = 0;
    active = 0;
    exist    = 1'b1;
    submit_n = 1'b0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("[TB] FAIL gs_busy: got busy=0 expected 1 within 40 cycles");
    end
    repeat (4) @(negedge clk);
    clear_scores();
    checks++;
    if (score_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gs_valid: got %0b expected 0", score_valid);
    end
    submit_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (score_valid === 1'b1 || busy === 1'b1) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("[TB] FAIL gs_abort: got %0d active cycles expected 0", active);
    end
    // game_start in the very cycle the press matures: the press is discarded.
    active   = 0;
    submit_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      game_start = (k == DEB + 1);
      if (k == 25) submit_n = 1'b1;
      if (score_valid === 1'b1 || busy === 1'b1) active++;
    end
    game_start = 1'b0;
    checks++;
    if (active != 0 || correct_cnt !== 7'd0) begin
      errors++;
      $display("[TB] FAIL gs_same_cycle: got active=%0d c=%0d expected 0 0", active, correct_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_scores();
    for (int i = 0; i < 105; i++) do_press(1'b1, 25, "sat_correct");
    checks++;
    if ({correct_cnt, wrong_cnt, percent} !== {7'd99, 7'd0, 7'd100}) begin
      errors++;
      $display("[TB] FAIL sat_final: got c=%0d w=%0d p=%0d expected 99 0 100",
               correct_cnt, wrong_cnt, percent);
    end
    do_press(1'b0, 25, "sat_wrong");
    checks++;
    if ({correct_cnt, wrong_cnt, percent} !== {7'd99, 7'd1, 7'd99}) begin
      errors++;
      $display("[TB] FAIL sat_after_wrong: got c=%0d w=%0d p=%0d expected 99 1 99",
               correct_cnt, wrong_cnt, percent);
    end
  endtask

  task automatic test_random();
    clear_scores();
    for (int i = 0; i < 20; i++) begin
      do_press(1'($urandom_range(0, 1)), 6 + int'($urandom_range(0, 24)), "random");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_correct = 0;
    m_wrong   = 0;
    test_reset();
    test_scoring();
    test_reset_mid_div();
    test_round_case();
    test_bounce();
    test_back_to_back();
    test_game_start();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
